// File: rtl/hc595_rx_if.sv
// hc595_rx_if: serial lines of a 74HC595 display chain.
//   ds   - serial data
//   shcp - shift clock; data taken on its rising edge
//   stcp - storage clock; frame committed on its rising edge
//   oe   - active-low output enable
// master drives the lines (driver or bench), slave observes them (receiver).
interface hc595_rx_if;
  logic ds;
  logic shcp;
  logic stcp;
  logic oe;

  modport master (output ds, shcp, stcp, oe);
  modport slave  (input  ds, shcp, stcp, oe);
endinterface

// File: rtl/hc595_rx.sv
// hc595_rx: serial-to-parallel receiver for the 14-bit 74HC595 display chain.
// Rebuilds the 6-bit digit select and the 8-bit segment word from a driver's
// ds/shcp/stcp/oe stream.
//   sys_clk      in   system clock, rising edge
//   sys_rst      in   synchronous active-high reset
//   bus          in   serial lines (ds, shcp, stcp, oe), asynchronous to sys_clk
//   sel[5:0]     out  digit select, bit 0 = rightmost digit
//   seg[7:0]     out  segments {DP,G,F,E,D,C,B,A}
//   blank        out  synchronized oe; 1 = driver outputs disabled
//   frame_valid  out  1-cycle pulse, sel/seg updated this cycle
//   frame_err    out  1-cycle pulse, latch seen with a bad bit count
module hc595_rx #(
  parameter int FRAME_BITS  = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  hc595_rx_if.slave        bus,
  output logic [5:0]       sel,
  output logic [7:0]       seg,
  output logic             blank,
  output logic             frame_valid,
  output logic             frame_err
);

  localparam logic [3:0] FRAME_CNT = 4'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] ds_sync;
  logic [SYNC_STAGES-1:0] shcp_sync;
  logic [SYNC_STAGES-1:0] stcp_sync;
  logic [SYNC_STAGES-1:0] oe_sync;
  logic                   shcp_hist;
  logic                   stcp_hist;

  logic [FRAME_BITS-1:0]  sr;
  logic [3:0]             bit_cnt;

  // Latch decision stage: captures the pre-shift frame and count verdict
  // in the cycle the stcp rise is seen, so a coincident shift cannot leak in.
  logic                   dec_valid;
  logic                   dec_err;
  logic [FRAME_BITS-1:0]  dec_word;
  logic [5:0]             sel_next;

  logic ds_s;
  logic shcp_rise;
  logic stcp_rise;

  assign ds_s      = ds_sync[SYNC_STAGES-1];
  assign shcp_rise = shcp_sync[SYNC_STAGES-1] & ~shcp_hist;
  assign stcp_rise = stcp_sync[SYNC_STAGES-1] & ~stcp_hist;
  assign blank     = oe_sync[SYNC_STAGES-1];

  // First bit shifted in ends up in the MSB and drives sel[0].
  always_comb begin
    sel_next = '0;
    for (int i = 0; i < 6; i++) begin
      sel_next[i] = dec_word[FRAME_BITS-1-i];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ds_sync     <= '0;
      shcp_sync   <= '0;
      stcp_sync   <= '0;
      // oe idles disabled, so blank reads 1 while held in reset.
      oe_sync     <= '1;
      shcp_hist   <= 1'b0;
      stcp_hist   <= 1'b0;
      sr          <= '0;
      bit_cnt     <= '0;
      dec_valid   <= 1'b0;
      dec_err     <= 1'b0;
      dec_word    <= '0;
      sel         <= '0;
      seg         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      ds_sync   <= {ds_sync[SYNC_STAGES-2:0],   bus.ds};
      shcp_sync <= {shcp_sync[SYNC_STAGES-2:0], bus.shcp};
      stcp_sync <= {stcp_sync[SYNC_STAGES-2:0], bus.stcp};
      oe_sync   <= {oe_sync[SYNC_STAGES-2:0],   bus.oe};
      shcp_hist <= shcp_sync[SYNC_STAGES-1];
      stcp_hist <= stcp_sync[SYNC_STAGES-1];

      if (shcp_rise) begin
        sr <= {sr[FRAME_BITS-2:0], ds_s};
      end

      // A latch restarts the count; a coincident shift is the new frame's bit 0.
      if (stcp_rise) begin
        bit_cnt <= shcp_rise ? 4'd1 : 4'd0;
      end else if (shcp_rise && bit_cnt != 4'hF) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      dec_valid <= stcp_rise && (bit_cnt == FRAME_CNT);
      dec_err   <= stcp_rise && (bit_cnt != 4'd0) && (bit_cnt != FRAME_CNT);
      if (stcp_rise) begin
        dec_word <= sr;
      end

      frame_valid <= dec_valid;
      frame_err   <= dec_err;
      if (dec_valid) begin
        sel <= sel_next;
        seg <= dec_word[7:0];
      end
    end
  end

endmodule

// File: tb/tb_hc595_rx.sv
// tb_hc595_rx: bench for hc595_rx. Drives the serial lines at the falling
// edge, keeps a queue of expected frame results and compares each DUT pulse
// against the head of the queue.
module tb_hc595_rx;
  localparam int SYNC = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       blank;
  logic       frame_valid;
  logic       frame_err;

  hc595_rx_if bus ();

  hc595_rx #(.FRAME_BITS(14), .SYNC_STAGES(SYNC)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bus         (bus),
    .sel         (sel),
    .seg         (seg),
    .blank       (blank),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       err;
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t       q[$];
  logic [5:0] mdl_sel = '0;
  logic [7:0] mdl_seg = '0;
  int         checks  = 0;
  int         errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_good(input logic [5:0] s, input logic [7:0] g);
    q.push_back('{err: 1'b0, sel: s, seg: g});
    mdl_sel = s;
    mdl_seg = g;
  endtask

  task automatic push_err();
    q.push_back('{err: 1'b1, sel: mdl_sel, seg: mdl_seg});
  endtask

  // Bit k of a frame: k=0..5 -> sel[k], k=6..13 -> seg[13-k], beyond -> 0.
  function automatic logic frame_bit(input logic [5:0] s, input logic [7:0] g, input int k);
    if (k < 6)  return s[k];
    if (k < 14) return g[13-k];
    return 1'b0;
  endfunction

  task automatic shift_bit(input logic b);
    @(negedge sys_clk) bus.ds = b;
    repeat (2) @(negedge sys_clk);
    bus.shcp = 1'b1;
    repeat (3) @(negedge sys_clk);
    bus.shcp = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_bits(input logic [5:0] s, input logic [7:0] g, input int first, input int last);
    for (int k = first; k <= last; k++) shift_bit(frame_bit(s, g, k));
  endtask

  task automatic latch();
    @(negedge sys_clk) bus.stcp = 1'b1;
    repeat (3) @(negedge sys_clk);
    bus.stcp = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [5:0] s, input logic [7:0] g);
    send_bits(s, g, 0, 13);
    push_good(s, g);
    latch();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge sys_clk);
      t++;
    end
    #2;
    chk("drain_timeout", q.size(), 0);
  endtask

  // Scoreboard monitor.
  always @(posedge sys_clk) begin
    #1;
    if (!sys_rst && (frame_valid || frame_err)) begin
      chk("vld_err_excl", frame_valid & frame_err, 1'b0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {frame_valid, frame_err}, 2'b00);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", frame_err, e.err);
        chk("sel", sel, e.sel);
        chk("seg", seg, e.seg);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sys_rst  = 1'b1;
    bus.ds   = 1'b0;
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    bus.oe   = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("rst_sel", sel, 6'h00);
    chk("rst_seg", seg, 8'h00);
    chk("rst_blank", blank, 1'b1);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    sys_rst = 1'b0;
    bus.oe  = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("blank_enabled", blank, 1'b0);

    // 1: initial empty latch ignored, first frame with latency measurement.
    latch();
    send_bits(6'h01, 8'hC0, 0, 13);
    push_good(6'h01, 8'hC0);
    @(negedge sys_clk) bus.stcp = 1'b1;
    n = 0;
    do begin
      @(posedge sys_clk);
      n++;
      #1;
    end while (!frame_valid && n < 20);
    chk("latch_latency", n, SYNC + 2);
    repeat (3) @(negedge sys_clk);
    bus.stcp = 1'b0;
    repeat (3) @(negedge sys_clk);
    wait_drain();
    chk("f1_sel", sel, 6'h01);
    chk("f1_seg", seg, 8'hC0);

    // 2: continuous frames.
    for (int i = 0; i < 6; i++) begin
      logic [5:0] s;
      s = 6'h01 << (i % 3);
      send_frame(s, (i % 2) ? 8'hA4 : 8'hF9);
    end
    wait_drain();

    // 3: short, long and saturating counts, then recovery.
    send_bits(6'h2A, 8'h55, 0, 12);
    push_err();
    latch();
    send_bits(6'h15, 8'hAA, 0, 14);
    push_err();
    latch();
    send_bits(6'h3F, 8'hFF, 0, 29);
    push_err();
    latch();
    wait_drain();
    chk("err_hold_sel", sel, mdl_sel);
    chk("err_hold_seg", seg, mdl_seg);
    send_frame(6'h15, 8'h92);
    wait_drain();

    // 4: reset mid-frame.
    send_bits(6'h0C, 8'h3C, 0, 6);
    @(negedge sys_clk) sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("midrst_sel", sel, 6'h00);
    chk("midrst_seg", seg, 8'h00);
    chk("midrst_blank", blank, 1'b1);
    sys_rst = 1'b0;
    mdl_sel = '0;
    mdl_seg = '0;
    repeat (3) @(negedge sys_clk);
    send_frame(6'h20, 8'h7F);
    wait_drain();

    // 5: shcp and stcp rise together after 14 bits.
    send_bits(6'h04, 8'h99, 0, 13);
    @(negedge sys_clk) bus.ds = frame_bit(6'h02, 8'hB0, 0);
    repeat (2) @(negedge sys_clk);
    push_good(6'h04, 8'h99);
    bus.shcp = 1'b1;
    bus.stcp = 1'b1;
    repeat (3) @(negedge sys_clk);
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    repeat (3) @(negedge sys_clk);
    send_bits(6'h02, 8'hB0, 1, 13);
    push_good(6'h02, 8'hB0);
    latch();
    wait_drain();

    // 6: oe toggles mid-frame.
    send_bits(6'h08, 8'h82, 0, 4);
    @(negedge sys_clk) bus.oe = 1'b1;
    n = 0;
    do begin
      @(posedge sys_clk);
      n++;
      #1;
    end while (blank !== 1'b1 && n < 20);
    chk("blank_rise_lat", n, SYNC);
    @(negedge sys_clk) bus.oe = 1'b0;
    n = 0;
    do begin
      @(posedge sys_clk);
      n++;
      #1;
    end while (blank !== 1'b0 && n < 20);
    chk("blank_fall_lat", n, SYNC);
    send_bits(6'h08, 8'h82, 5, 13);
    push_good(6'h08, 8'h82);
    latch();
    wait_drain();

    repeat (10) @(negedge sys_clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
